// File: rtl/fano_sync_pkg.sv
// rtl/fano_sync_pkg.sv - shared state encoding and saturating helpers for the sync scheduler
package fano_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    // Helpers work on a 32-bit carrier; callers cast to their own width (<= 32).
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

    function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] v);
        return (v == '0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/sync_window_meter.sv
// rtl/sync_window_meter.sv - per-window vld/metric counters with latched dwell and threshold
module sync_window_meter
    import fano_sync_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             open,
    input  logic             start,
    input  logic             vld,
    input  logic             t_up,
    input  logic             t_down,
    input  logic [CNT_W-1:0] dwell_len,
    input  logic [CNT_W-1:0] good_thr,
    output logic             win_done,
    output logic             win_good
);

    logic [CNT_W-1:0] vld_cnt;
    logic [CNT_W-1:0] metric;
    logic [CNT_W-1:0] metric_nxt;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] dwell_eff;
    logic             last_vld;

    always_comb begin
        dwell_eff  = (dwell_len == '0) ? CNT_W'(1) : dwell_len;
        metric_nxt = metric;
        if (t_up) begin
            metric_nxt = CNT_W'(sat_inc(SAT_W'(metric), SAT_W'({CNT_W{1'b1}})));
        end else if (t_down) begin
            metric_nxt = CNT_W'(sat_dec(SAT_W'(metric)));
        end
        last_vld = vld && ((vld_cnt + CNT_W'(1)) == dwell_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_cnt  <= '0;
            metric   <= '0;
            dwell_q  <= CNT_W'(1);
            thr_q    <= '0;
            win_done <= 1'b0;
            win_good <= 1'b0;
        end else if (start) begin
            vld_cnt  <= '0;
            metric   <= '0;
            dwell_q  <= dwell_eff;
            thr_q    <= good_thr;
            win_done <= 1'b0;
            win_good <= 1'b0;
        end else if (!open) begin
            vld_cnt  <= '0;
            metric   <= '0;
            win_done <= 1'b0;
            win_good <= 1'b0;
        end else begin
            win_done <= 1'b0;
            metric   <= metric_nxt;
            if (last_vld) begin
                // Verdict includes this cycle's event; the next window starts clean with fresh config.
                win_done <= 1'b1;
                win_good <= (metric_nxt > thr_q);
                vld_cnt  <= '0;
                metric   <= '0;
                dwell_q  <= dwell_eff;
                thr_q    <= good_thr;
            end else if (vld) begin
                vld_cnt <= vld_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sync_hypothesis_scheduler.sv
// rtl/sync_hypothesis_scheduler.sv - sweeps (phase x depuncturer) hypotheses with lock hysteresis
module sync_hypothesis_scheduler
    import fano_sync_pkg::*;
#(
    parameter int N_PHASE   = 4,
    parameter int N_DEPERF  = 2,
    parameter int CNT_W     = 24,
    parameter int HYST_W    = 4,
    parameter int FLUSH_CYC = 16,
    localparam int PH_W = (N_PHASE > 1) ? $clog2(N_PHASE) : 1,
    localparam int DP_W = (N_DEPERF > 1) ? $clog2(N_DEPERF) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_vld,
    input  logic              i_T_up,
    input  logic              i_T_down,
    input  logic              i_restart,
    input  logic [CNT_W-1:0]  i_dwell_len,
    input  logic [CNT_W-1:0]  i_good_thr,
    input  logic [HYST_W-1:0] i_lock_cnt,
    input  logic [HYST_W-1:0] i_unlock_cnt,
    output logic [PH_W-1:0]   o_phase,
    output logic [DP_W-1:0]   o_deperf_st,
    output logic              o_hyp_load,
    output logic              o_llr_reset,
    output logic              o_is_sync,
    output logic              o_sweep_wrap
);

    localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase, phase_nxt;
    logic [DP_W-1:0]   deperf, deperf_nxt;
    logic [HYST_W-1:0] good_cnt, good_nxt;
    logic [HYST_W-1:0] bad_cnt, bad_nxt;
    logic [HYST_W-1:0] lock_eff, unlock_eff;
    logic [FL_W-1:0]   flush_cnt, flush_nxt;
    logic              hyp_load, hyp_load_nxt;
    logic              sweep_wrap, sweep_wrap_nxt;
    logic              is_sync;
    logic              advance;
    logic              win_start;
    logic              win_open;
    logic              win_done;
    logic              win_good;

    assign win_open = (state == SEARCH) || (state == VERIFY) || (state == LOCKED);

    sync_window_meter #(
        .CNT_W (CNT_W)
    ) u_meter (
        .clk       (clk),
        .reset_n   (reset_n),
        .open      (win_open),
        .start     (win_start),
        .vld       (i_vld),
        .t_up      (i_T_up),
        .t_down    (i_T_down),
        .dwell_len (i_dwell_len),
        .good_thr  (i_good_thr),
        .win_done  (win_done),
        .win_good  (win_good)
    );

    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        deperf_nxt     = deperf;
        good_nxt       = good_cnt;
        bad_nxt        = bad_cnt;
        flush_nxt      = flush_cnt;
        hyp_load_nxt   = 1'b0;
        sweep_wrap_nxt = 1'b0;
        advance        = 1'b0;
        win_start      = 1'b0;
        lock_eff       = (i_lock_cnt == '0) ? HYST_W'(1) : i_lock_cnt;
        unlock_eff     = (i_unlock_cnt == '0) ? HYST_W'(1) : i_unlock_cnt;

        case (state)
            IDLE: begin
                state_nxt    = FLUSH;
                hyp_load_nxt = 1'b1;
                flush_nxt    = '0;
            end
            FLUSH: begin
                if (flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
                    state_nxt = SEARCH;
                    win_start = 1'b1;
                end else begin
                    flush_nxt = flush_cnt + FL_W'(1);
                end
            end
            SEARCH: begin
                if (win_done) begin
                    if (!win_good) begin
                        advance = 1'b1;
                    end else if (lock_eff == HYST_W'(1)) begin
                        state_nxt = LOCKED;
                        bad_nxt   = '0;
                    end else begin
                        state_nxt = VERIFY;
                        good_nxt  = HYST_W'(1);
                    end
                end
            end
            VERIFY: begin
                if (win_done) begin
                    if (!win_good) begin
                        advance = 1'b1;
                    end else begin
                        good_nxt = good_cnt + HYST_W'(1);
                        if ((good_cnt + HYST_W'(1)) == lock_eff) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                        end
                    end
                end
            end
            LOCKED: begin
                if (win_done) begin
                    if (win_good) begin
                        bad_nxt = '0;
                    end else if ((bad_cnt + HYST_W'(1)) == unlock_eff) begin
                        advance = 1'b1;
                    end else begin
                        bad_nxt = bad_cnt + HYST_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Phase is the inner loop of the sweep, depuncturer state the outer one.
        if (advance) begin
            if (phase == PH_W'(N_PHASE - 1)) begin
                phase_nxt = '0;
                if (deperf == DP_W'(N_DEPERF - 1)) begin
                    deperf_nxt     = '0;
                    sweep_wrap_nxt = 1'b1;
                end else begin
                    deperf_nxt = deperf + DP_W'(1);
                end
            end else begin
                phase_nxt = phase + PH_W'(1);
            end
            state_nxt    = FLUSH;
            hyp_load_nxt = 1'b1;
            good_nxt     = '0;
            bad_nxt      = '0;
            flush_nxt    = '0;
        end

        if (i_restart) begin
            phase_nxt      = '0;
            deperf_nxt     = '0;
            state_nxt      = FLUSH;
            hyp_load_nxt   = 1'b1;
            sweep_wrap_nxt = 1'b0;
            good_nxt       = '0;
            bad_nxt        = '0;
            flush_nxt      = '0;
            win_start      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase      <= '0;
            deperf     <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            flush_cnt  <= '0;
            hyp_load   <= 1'b0;
            sweep_wrap <= 1'b0;
            is_sync    <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            deperf     <= deperf_nxt;
            good_cnt   <= good_nxt;
            bad_cnt    <= bad_nxt;
            flush_cnt  <= flush_nxt;
            hyp_load   <= hyp_load_nxt;
            sweep_wrap <= sweep_wrap_nxt;
            is_sync    <= (state_nxt == LOCKED);
        end
    end

    assign o_phase      = phase;
    assign o_deperf_st  = deperf;
    assign o_hyp_load   = hyp_load;
    assign o_llr_reset  = (state == FLUSH);
    assign o_is_sync    = is_sync;
    assign o_sweep_wrap = sweep_wrap;

endmodule

// File: tb/tb_sync_hypothesis_scheduler.sv
// tb/tb_sync_hypothesis_scheduler.sv - directed self-checking bench for sync_hypothesis_scheduler
module tb_sync_hypothesis_scheduler;

    localparam int CNT_W  = 24;
    localparam int HYST_W = 4;

    localparam int M_NONE  = 0;
    localparam int M_T23   = 1;
    localparam int M_T4    = 2;
    localparam int M_BAD4  = 3;
    localparam int M_ALLUP = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_vld;
    logic              i_T_up;
    logic              i_T_down;
    logic              i_restart;
    logic [CNT_W-1:0]  i_dwell_len;
    logic [CNT_W-1:0]  i_good_thr;
    logic [HYST_W-1:0] i_lock_cnt;
    logic [HYST_W-1:0] i_unlock_cnt;
    logic [1:0]        o_phase;
    logic [0:0]        o_deperf_st;
    logic              o_hyp_load;
    logic              o_llr_reset;
    logic              o_is_sync;
    logic              o_sweep_wrap;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int last_load = 0;
    int pos       = 0;
    int idx       = 0;
    int mode      = M_NONE;
    int wraps     = 0;
    int sync_at[16];

    always #5 clk = ~clk;

    sync_hypothesis_scheduler #(
        .N_PHASE   (4),
        .N_DEPERF  (2),
        .CNT_W     (CNT_W),
        .HYST_W    (HYST_W),
        .FLUSH_CYC (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_vld        (i_vld),
        .i_T_up       (i_T_up),
        .i_T_down     (i_T_down),
        .i_restart    (i_restart),
        .i_dwell_len  (i_dwell_len),
        .i_good_thr   (i_good_thr),
        .i_lock_cnt   (i_lock_cnt),
        .i_unlock_cnt (i_unlock_cnt),
        .o_phase      (o_phase),
        .o_deperf_st  (o_deperf_st),
        .o_hyp_load   (o_hyp_load),
        .o_llr_reset  (o_llr_reset),
        .o_is_sync    (o_is_sync),
        .o_sweep_wrap (o_sweep_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of T events from the window position the bench tracks, then advances a clock.
    task automatic tick();
        logic up, dn;
        int   d_eff;
        up    = 1'b0;
        dn    = 1'b0;
        d_eff = (i_dwell_len == '0) ? 1 : int'(i_dwell_len);
        if (o_llr_reset) begin
            pos = 0;
            idx = 0;
            foreach (sync_at[k]) sync_at[k] = 2;
        end else begin
            case (mode)
                M_T23: up = (o_phase == 2'd2) && (o_deperf_st == 1'b1) && (pos < 5) &&
                            !(idx == 2 || idx == 4 || idx == 5 || idx == 6);
                M_T4: begin
                    dn = (pos < 6);
                    up = (pos >= 2) && (pos < 6);
                end
                M_BAD4: begin
                    dn = (pos < 6);
                    up = (pos < 4);
                end
                M_ALLUP: up = 1'b1;
                default: ;
            endcase
            if (pos == 1 && idx < 16) sync_at[idx] = int'(o_is_sync);
            pos++;
            if (pos >= d_eff) begin
                pos = 0;
                idx++;
            end
        end
        i_T_up   = up;
        i_T_down = dn;
        @(posedge clk);
        #1;
        cyc++;
        if (o_sweep_wrap) wraps++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_load(input string tag, input int ph, input int dp, input int wrap,
                             input int gap);
        int n;
        tick();
        n = 1;
        while (!o_hyp_load && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(o_hyp_load), 1);
        check({tag, "_ph"}, 32'(o_phase), ph);
        check({tag, "_dp"}, 32'(o_deperf_st), dp);
        check({tag, "_wrap"}, 32'(o_sweep_wrap), wrap);
        if (gap > 0) check({tag, "_gap"}, cyc - last_load, gap);
        last_load = cyc;
    endtask

    task automatic count_flush(input string tag);
        int n;
        n = 0;
        while (o_llr_reset && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, 16);
    endtask

    int exp_ph[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_dp[8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        reset_n      = 1'b0;
        i_vld        = 1'b1;
        i_T_up       = 1'b0;
        i_T_down     = 1'b0;
        i_restart    = 1'b0;
        i_dwell_len  = CNT_W'(8);
        i_good_thr   = CNT_W'(3);
        i_lock_cnt   = HYST_W'(2);
        i_unlock_cnt = HYST_W'(3);
        foreach (sync_at[k]) sync_at[k] = 2;
        ticks(3);
        check("reset_outs", 32'({o_phase, o_deperf_st, o_hyp_load, o_llr_reset, o_is_sync,
                                 o_sweep_wrap}), 0);

        // Full sweep with no threshold activity: every window bad.
        reset_n = 1'b1;
        wait_load("t1_first", 0, 0, 0, 0);
        count_flush("t1_flush_len");
        for (int i = 0; i < 8; i++) begin
            wait_load($sformatf("t1_hyp%0d", i), exp_ph[i], exp_dp[i], (i == 7) ? 1 : 0, 25);
        end
        check("t1_wraps", wraps, 1);

        // Only (2,1) shows activity; lock after two good windows, unlock after three bad in a row.
        mode = M_T23;
        wait_load("t2_h10", 1, 0, 0, 25);
        wait_load("t2_h20", 2, 0, 0, 25);
        wait_load("t2_h30", 3, 0, 0, 25);
        wait_load("t2_h01", 0, 1, 0, 25);
        wait_load("t2_h11", 1, 1, 0, 25);
        wait_load("t2_h21", 2, 1, 0, 25);
        wait_load("t3_h31", 3, 1, 0, 73);
        check("t2_verify_nosync", sync_at[1], 0);
        check("t2_locked", sync_at[2], 1);
        check("t3_bad1_held", sync_at[3], 1);
        check("t3_good_held", sync_at[4], 1);
        check("t3_bad1b_held", sync_at[5], 1);
        check("t3_bad2_held", sync_at[6], 1);
        check("t3_unlocked", 32'(o_is_sync), 0);

        // Simultaneous up/down (up wins) and floor at zero; single good window locks with lock=1.
        mode         = M_T4;
        i_dwell_len  = CNT_W'(6);
        i_lock_cnt   = HYST_W'(1);
        ticks(22);
        check("t4_pre_lock", 32'(o_is_sync), 0);
        mode         = M_BAD4;
        i_unlock_cnt = HYST_W'(1);
        tick();
        check("t4_metric_good", 32'(o_is_sync), 1);
        wait_load("t4_unlock_wrap", 0, 0, 1, 29);
        check("t4_wraps", wraps, 2);

        // Lock at (3,0), then restart.
        mode        = M_NONE;
        i_dwell_len = CNT_W'(8);
        wait_load("t5_h10", 1, 0, 0, 25);
        wait_load("t5_h20", 2, 0, 0, 25);
        wait_load("t5_h30", 3, 0, 0, 25);
        mode = M_ALLUP;
        ticks(24);
        check("t5_pre_lock", 32'(o_is_sync), 0);
        tick();
        check("t5_locked", 32'(o_is_sync), 1);
        ticks(3);
        check("t5_still_locked", 32'(o_is_sync), 1);
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        last_load = cyc;
        check("t5_rst_sync", 32'(o_is_sync), 0);
        check("t5_rst_hyp", 32'({o_phase, o_deperf_st}), 0);
        check("t5_rst_load", 32'(o_hyp_load), 1);
        check("t5_rst_nowrap", 32'(o_sweep_wrap), 0);
        check("t5_rst_flush", 32'(o_llr_reset), 1);
        check("t5_wraps", wraps, 2);

        // Reset mid-flush, then zero dwell and zero lock count behave as 1.
        ticks(5);
        reset_n = 1'b0;
        ticks(2);
        check("t6_reset_outs", 32'({o_phase, o_deperf_st, o_hyp_load, o_llr_reset, o_is_sync,
                                    o_sweep_wrap}), 0);
        i_dwell_len = '0;
        i_lock_cnt  = '0;
        i_good_thr  = '0;
        reset_n     = 1'b1;
        wait_load("t6_first", 0, 0, 0, 0);
        ticks(17);
        check("t6_pre_lock", 32'(o_is_sync), 0);
        tick();
        check("t6_one_vld_lock", 32'(o_is_sync), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
